tx_gearbox66: RTL and testbench

- Transmit-side 66b-to-32b gearbox for the 64b/66b link.
- Accepts 66-bit blocks (2-bit sync header plus 64-bit payload) over a valid/ready handshake and emits a continuous stream of 32-bit words.
- Emits header bits first, so the receive-side gearbox and header-alignment logic can lock on the 01/10 sync headers.
- Inserts idle blocks when upstream has no data, so the serial line never starves.

---
 rtl/tx_gearbox66_pkg.sv | 20 ++
 rtl/tx_gearbox66_if.sv | 22 ++
 rtl/tx_gearbox66.sv | 93 +++++++++
 tb/tb_tx_gearbox66.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tx_gearbox66_pkg.sv
// Shared 64b/66b gearbox definitions, used by both the TX and RX sides of the link.
package gbox_pkg;

    localparam logic [1:0]  c_DATA_HEADER = 2'b01;
    localparam logic [1:0]  c_CMD_HEADER  = 2'b10;
    localparam int          c_BLK_W       = 66;
    localparam int          c_WORD_W      = 32;
    localparam int          c_BUF_W       = 97;
    localparam logic [63:0] c_IDLE_DATA   = 64'h1E00_0000_0000_0000;

    typedef struct packed {
        logic [1:0]  hdr;
        logic [63:0] data;
    } blk66_t;

    function automatic logic hdr_is_valid(input logic [1:0] hdr);
        return (hdr == c_DATA_HEADER) || (hdr == c_CMD_HEADER);
    endfunction

endpackage

// File: rtl/tx_gearbox66_if.sv
// Block-in / word-out bus of the TX gearbox; master is the upstream block source.
interface tx_gearbox66_if;
    import gbox_pkg::*;

    logic [1:0]          blk_hdr_i;
    logic [63:0]         blk_data_i;
    logic                blk_valid_i;
    logic                blk_ready_o;
    logic [c_WORD_W-1:0] word_o;
    logic                word_valid_o;

    modport master (
        output blk_hdr_i, blk_data_i, blk_valid_i,
        input  blk_ready_o, word_o, word_valid_o
    );

    modport slave (
        input  blk_hdr_i, blk_data_i, blk_valid_i,
        output blk_ready_o, word_o, word_valid_o
    );

endinterface

// File: rtl/tx_gearbox66.sv
// 66b-to-32b transmit gearbox: left-justified bit buffer drained 32 bits per cycle,
// refilled with upstream blocks or, when enabled, idle blocks.
module tx_gearbox66
    import gbox_pkg::*;
#(
    parameter bit          IDLE_EN   = 1'b1,
    parameter logic [63:0] IDLE_DATA = c_IDLE_DATA
) (
    input  logic          clk_i,
    input  logic          rst_i,
    tx_gearbox66_if.slave bus,
    output logic          hdr_err_o,
    output logic [15:0]   idle_cnt_o,
    output logic [15:0]   blk_cnt_o
);

    localparam logic [6:0] c_WORD_OCC = 7'(c_WORD_W);
    localparam logic [6:0] c_BLK_OCC  = 7'(c_BLK_W);

    logic [c_BUF_W-1:0]  r_buf;
    logic [6:0]          r_occ;
    logic [c_WORD_W-1:0] r_word;
    logic                r_word_valid;
    logic                r_hdr_err;
    logic [15:0]         r_idle_cnt;
    logic [15:0]         r_blk_cnt;

    logic                w_emit;
    logic [6:0]          w_resid;
    logic [c_BUF_W-1:0]  w_shifted;
    logic                w_ready;
    logic                w_take_blk;
    logic                w_take_idle;
    logic                w_hdr_bad;
    blk66_t              w_app_blk;
    logic [c_BUF_W-1:0]  w_app_vec;
    logic [c_BUF_W-1:0]  w_buf_next;
    logic [6:0]          w_occ_next;

    // Bits below the occupancy are always zero, so appending is a plain OR at offset R.
    always_comb begin
        w_emit      = (r_occ >= c_WORD_OCC);
        w_resid     = w_emit ? (r_occ - c_WORD_OCC) : r_occ;
        w_shifted   = w_emit ? (r_buf << c_WORD_W) : r_buf;
        w_ready     = (w_resid < c_WORD_OCC);
        w_take_blk  = bus.blk_valid_i && w_ready;
        w_take_idle = IDLE_EN && w_ready && !bus.blk_valid_i;
        w_hdr_bad   = w_take_blk && !hdr_is_valid(bus.blk_hdr_i);
        w_app_blk   = w_take_blk ? blk66_t'{hdr: bus.blk_hdr_i, data: bus.blk_data_i}
                                 : blk66_t'{hdr: c_CMD_HEADER, data: IDLE_DATA};
        w_app_vec   = {w_app_blk, {(c_BUF_W - c_BLK_W){1'b0}}} >> w_resid;
        w_buf_next  = w_shifted;
        w_occ_next  = w_resid;
        if (w_take_blk || w_take_idle) begin
            w_buf_next = w_shifted | w_app_vec;
            w_occ_next = w_resid + c_BLK_OCC;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_buf        <= '0;
            r_occ        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_hdr_err    <= 1'b0;
            r_idle_cnt   <= '0;
            r_blk_cnt    <= '0;
        end else begin
            r_buf        <= w_buf_next;
            r_occ        <= w_occ_next;
            r_word_valid <= w_emit;
            r_hdr_err    <= w_hdr_bad;
            if (w_emit) begin
                r_word <= r_buf[c_BUF_W-1 -: c_WORD_W];
            end
            if (w_take_blk) begin
                r_blk_cnt <= r_blk_cnt + 16'd1;
            end
            if (w_take_idle && (r_idle_cnt != 16'hFFFF)) begin
                r_idle_cnt <= r_idle_cnt + 16'd1;
            end
        end
    end

    assign bus.blk_ready_o  = w_ready;
    assign bus.word_o       = r_word;
    assign bus.word_valid_o = r_word_valid;
    assign hdr_err_o        = r_hdr_err;
    assign idle_cnt_o       = r_idle_cnt;
    assign blk_cnt_o        = r_blk_cnt;

endmodule

// File: tb/tb_tx_gearbox66.sv
// Directed bench for tx_gearbox66: dut0 runs without idle insertion, dut1 with it.
module tb_tx_gearbox66;
    import gbox_pkg::*;

    logic        clk;
    logic        rst;
    logic        hdrErr0, hdrErr1;
    logic [15:0] idleCnt0, blkCnt0, idleCnt1, blkCnt1;
    int          testCount = 0;
    int          failCount = 0;

    tx_gearbox66_if ifc0();
    tx_gearbox66_if ifc1();

    tx_gearbox66 #(.IDLE_EN(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .bus(ifc0),
        .hdr_err_o(hdrErr0), .idle_cnt_o(idleCnt0), .blk_cnt_o(blkCnt0)
    );

    tx_gearbox66 #(.IDLE_EN(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .bus(ifc1),
        .hdr_err_o(hdrErr1), .idle_cnt_o(idleCnt1), .blk_cnt_o(blkCnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [65:0] blkA = {2'b01, 64'hA5A5_0000_FFFF_1234};
    logic [65:0] blkC = {2'b10, 64'h0123_4567_89AB_CDEF};
    logic [65:0] blkBad = {2'b11, 64'hDEAD_BEEF_0000_0001};
    logic [65:0] rndBlk [0:169];
    bit          expQ0[$];
    bit          expQ1[$];

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [65:0] blk);
        ifc0.blk_valid_i = valid;
        ifc0.blk_hdr_i   = blk[65:64];
        ifc0.blk_data_i  = blk[63:0];
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic pushBlock(input int which, input logic [65:0] blk);
        for (int i = 65; i >= 0; i--) begin
            if (which == 0) expQ0.push_back(blk[i]);
            else            expQ1.push_back(blk[i]);
        end
    endtask

    task automatic popWord(input int which, output logic [31:0] w);
        w = '0;
        for (int i = 31; i >= 0; i--) begin
            if (which == 0 && expQ0.size() > 0) w[i] = expQ0.pop_front();
            if (which == 1 && expQ1.size() > 0) w[i] = expQ1.pop_front();
        end
    endtask

    // Enters with reset asserted; optionally re-asserts reset mid-block once B = 34.
    task automatic runStartup(input bit abortMid);
        logic [65:0] aThenC;
        applyStimulus(1'b1, blkA);
        waitEdge();
        checkOutput("rst_word_valid", ifc0.word_valid_o, 1'b0);
        checkOutput("rst_word", ifc0.word_o, 32'h0);
        checkOutput("rst_ready", ifc0.blk_ready_o, 1'b1);
        checkOutput("rst_blk_cnt", blkCnt0, 16'd0);
        rst = 1'b0;
        checkOutput("su_ready_e0", ifc0.blk_ready_o, 1'b1);
        waitEdge();
        checkOutput("su_blk_cnt_e1", blkCnt0, 16'd1);
        checkOutput("su_ready_e1", ifc0.blk_ready_o, 1'b0);
        checkOutput("su_valid_e1", ifc0.word_valid_o, 1'b0);
        applyStimulus(1'b1, blkC);
        waitEdge();
        checkOutput("su_word_e2", ifc0.word_o, blkA[65:34]);
        checkOutput("su_valid_e2", ifc0.word_valid_o, 1'b1);
        checkOutput("su_ready_e2", ifc0.blk_ready_o, 1'b1);
        checkOutput("su_blk_cnt_e2", blkCnt0, 16'd1);
        if (abortMid) begin
            #2;
            rst = 1'b1;
            #1;
            checkOutput("arst_word_valid", ifc0.word_valid_o, 1'b0);
            checkOutput("arst_word", ifc0.word_o, 32'h0);
            checkOutput("arst_ready", ifc0.blk_ready_o, 1'b1);
            checkOutput("arst_blk_cnt", blkCnt0, 16'd0);
            return;
        end
        waitEdge();
        checkOutput("su_word_e3", ifc0.word_o, blkA[33:2]);
        checkOutput("su_blk_cnt_e3", blkCnt0, 16'd2);
        checkOutput("su_ready_e3", ifc0.blk_ready_o, 1'b0);
        applyStimulus(1'b0, blkC);
        waitEdge();
        aThenC = {blkA[1:0], blkC[65:2]};
        checkOutput("su_word_e4", ifc0.word_o, aThenC[65:34]);
        checkOutput("su_ready_e4", ifc0.blk_ready_o, 1'b1);
        waitEdge();
        checkOutput("su_word_e5", ifc0.word_o, blkC[35:4]);
        checkOutput("su_valid_e5", ifc0.word_valid_o, 1'b1);
        waitEdge();
        checkOutput("su_valid_e6", ifc0.word_valid_o, 1'b0);
        checkOutput("su_word_hold_e6", ifc0.word_o, blkC[35:4]);
        checkOutput("su_blk_cnt_e6", blkCnt0, 16'd2);
    endtask

    initial begin
        int          idx;
        bit          hs;
        logic [31:0] expWord;
        logic [65:0] idleBlk;

        rst = 1'b1;
        ifc1.blk_valid_i = 1'b0;
        ifc1.blk_hdr_i   = 2'b00;
        ifc1.blk_data_i  = 64'h0;
        applyStimulus(1'b0, 66'h0);
        for (int i = 0; i < 170; i++) begin
            rndBlk[i] = {($urandom_range(0, 1) == 1) ? c_DATA_HEADER : c_CMD_HEADER,
                         $urandom(), $urandom()};
        end

        runStartup(1'b0);
        rst = 1'b1;
        runStartup(1'b1);
        runStartup(1'b0);

        // Invalid header still goes through untouched and flags a one-cycle error.
        rst = 1'b1;
        applyStimulus(1'b1, blkBad);
        waitEdge();
        rst = 1'b0;
        waitEdge();
        checkOutput("hdr_err_pulse", hdrErr0, 1'b1);
        checkOutput("hdr_blk_cnt", blkCnt0, 16'd1);
        applyStimulus(1'b0, blkBad);
        waitEdge();
        checkOutput("hdr_err_clear", hdrErr0, 1'b0);
        checkOutput("hdr_word", ifc0.word_o, blkBad[65:34]);
        checkOutput("hdr_blk_cnt_hold", blkCnt0, 16'd1);

        // Continuous valid input: a block is held until taken, then the next is offered.
        rst = 1'b1;
        applyStimulus(1'b0, 66'h0);
        waitEdge();
        rst = 1'b0;
        expQ0.delete();
        idx = 0;
        for (int e = 1; e <= 330; e++) begin
            applyStimulus(1'b1, rndBlk[idx]);
            hs = ifc0.blk_ready_o;
            waitEdge();
            if (hs) begin
                pushBlock(0, rndBlk[idx]);
                idx++;
            end
            if (e == 1) begin
                checkOutput("rnd_valid_first", ifc0.word_valid_o, 1'b0);
            end else begin
                checkOutput("rnd_valid", ifc0.word_valid_o, 1'b1);
                checkOutput("rnd_bits_avail", expQ0.size() >= 32, 1'b1);
                popWord(0, expWord);
                checkOutput("rnd_word", ifc0.word_o, expWord);
            end
        end
        applyStimulus(1'b0, 66'h0);
        checkOutput("rnd_accepted", idx, 160);
        checkOutput("rnd_blk_cnt", blkCnt0, 16'd160);

        // No upstream data: dut1 must fill the line with idle blocks.
        rst = 1'b1;
        waitEdge();
        rst = 1'b0;
        expQ1.delete();
        idleBlk = {c_CMD_HEADER, c_IDLE_DATA};
        for (int i = 0; i < 25; i++) pushBlock(1, idleBlk);
        for (int e = 1; e <= 40; e++) begin
            waitEdge();
            if (e == 1) begin
                checkOutput("idle_valid_first", ifc1.word_valid_o, 1'b0);
            end else begin
                checkOutput("idle_valid", ifc1.word_valid_o, 1'b1);
                popWord(1, expWord);
                checkOutput("idle_word", ifc1.word_o, expWord);
            end
        end
        checkOutput("idle_cnt", idleCnt1, 16'd20);
        checkOutput("idle_blk_cnt", blkCnt1, 16'd0);
        checkOutput("idle_off_cnt", idleCnt0, 16'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
